// File: rtl/alu_rs_pkg.sv
// Shared widths, opcode encoding and wakeup helper for the ALU reservation station.
package alu_rs_pkg;

    localparam int REG_WIDTH        = 32;
    localparam int ALU_OPCODE_WIDTH = 4;
    localparam int RS_DEPTH         = 4;
    localparam int TAG_WIDTH        = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // A pending operand captures the broadcast when its producer tag matches.
    function automatic logic cdb_wake(input logic cdb_valid, input logic rdy, input logic tag_eq);
        return cdb_valid & ~rdy & tag_eq;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and issue signals of the ALU reservation station.
interface alu_rs_if
    import alu_rs_pkg::*;
#(
    parameter int DEPTH  = RS_DEPTH,
    parameter int DATA_W = REG_WIDTH,
    parameter int OP_W   = ALU_OPCODE_WIDTH,
    parameter int TAG_W  = TAG_WIDTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [TAG_W-1:0]  in_dst_tag;
    logic              in_src1_rdy;
    logic [DATA_W-1:0] in_src1;
    logic [TAG_W-1:0]  in_src1_tag;
    logic              in_src2_rdy;
    logic [DATA_W-1:0] in_src2;
    logic [TAG_W-1:0]  in_src2_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              alu_valid;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [TAG_W-1:0]  alu_dst_tag;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, in_valid, in_opcode, in_dst_tag,
               in_src1_rdy, in_src1, in_src1_tag,
               in_src2_rdy, in_src2, in_src2_tag,
               cdb_valid, cdb_tag, cdb_data,
        input  in_ready, alu_valid, alu_opcode, alu_src1, alu_src2, alu_dst_tag, count
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_dst_tag,
               in_src1_rdy, in_src1, in_src1_tag,
               in_src2_rdy, in_src2, in_src2_tag,
               cdb_valid, cdb_tag, cdb_data,
        output in_ready, alu_valid, alu_opcode, alu_src1, alu_src2, alu_dst_tag, count
    );

endinterface

// File: rtl/alu_rs_operand.sv
// One operand slot of a station entry: ready/tag/value storage with CDB capture,
// loaded from dispatch (with same-cycle bypass) or from the next-younger entry on compaction.
module alu_rs_operand
    import alu_rs_pkg::*;
#(
    parameter int DATA_W = REG_WIDTH,
    parameter int TAG_W  = TAG_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              entry_valid,
    input  logic              nb_valid,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              load_new,
    input  logic              new_rdy,
    input  logic [TAG_W-1:0]  new_tag,
    input  logic [DATA_W-1:0] new_val,
    input  logic              shift,
    input  logic              nb_rdy,
    input  logic [TAG_W-1:0]  nb_tag,
    input  logic [DATA_W-1:0] nb_val,
    output logic              rdy,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] val
);

    logic              rdy_r;
    logic [TAG_W-1:0]  tag_r;
    logic [DATA_W-1:0] val_r;
    logic              own_hit_s;
    logic              nb_hit_s;
    logic              new_hit_s;
    logic              rdy_s;
    logic [TAG_W-1:0]  tag_s;
    logic [DATA_W-1:0] val_s;

    // Next slot contents; a shifted-in operand still sees this cycle's broadcast.
    always_comb begin
        own_hit_s = entry_valid & cdb_wake(cdb_valid, rdy_r, tag_r == cdb_tag);
        nb_hit_s  = nb_valid & cdb_wake(cdb_valid, nb_rdy, nb_tag == cdb_tag);
        new_hit_s = cdb_wake(cdb_valid, new_rdy, new_tag == cdb_tag);
        rdy_s     = rdy_r;
        tag_s     = tag_r;
        val_s     = val_r;
        if (load_new) begin
            rdy_s = new_rdy | new_hit_s;
            tag_s = new_tag;
            val_s = new_hit_s ? cdb_data : new_val;
        end else if (shift) begin
            rdy_s = nb_rdy | nb_hit_s;
            tag_s = nb_tag;
            val_s = nb_hit_s ? cdb_data : nb_val;
        end else begin
            rdy_s = rdy_r | own_hit_s;
            val_s = own_hit_s ? cdb_data : val_r;
        end
    end

    // Slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_r <= 1'b0;
            tag_r <= '0;
            val_r <= '0;
        end else if (clr) begin
            rdy_r <= 1'b0;
        end else begin
            rdy_r <= rdy_s;
            tag_r <= tag_s;
            val_r <= val_s;
        end
    end

    assign rdy = rdy_r;
    assign tag = tag_r;
    assign val = val_r;

endmodule

// File: rtl/alu_rs.sv
// Compacting ALU reservation station: entry 0 is always the oldest, the oldest
// fully-ready entry issues each cycle into registered ALU-side outputs.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH  = RS_DEPTH,
    parameter int DATA_W = REG_WIDTH,
    parameter int OP_W   = ALU_OPCODE_WIDTH,
    parameter int TAG_W  = TAG_WIDTH
) (
    input logic     clk,
    input logic     rst,
    alu_rs_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_r;
    logic [OP_W-1:0]   opcode_r [DEPTH];
    logic [TAG_W-1:0]  dst_r    [DEPTH];
    logic [CNT_W-1:0]  count_r;

    logic [DEPTH-1:0]  s1_rdy;
    logic [TAG_W-1:0]  s1_tag   [DEPTH];
    logic [DATA_W-1:0] s1_val   [DEPTH];
    logic [DEPTH-1:0]  s2_rdy;
    logic [TAG_W-1:0]  s2_tag   [DEPTH];
    logic [DATA_W-1:0] s2_val   [DEPTH];

    logic [DEPTH-1:0]  nb_valid;
    logic [OP_W-1:0]   nb_opcode [DEPTH];
    logic [TAG_W-1:0]  nb_dst    [DEPTH];
    logic [DEPTH-1:0]  nb_s1_rdy;
    logic [TAG_W-1:0]  nb_s1_tag [DEPTH];
    logic [DATA_W-1:0] nb_s1_val [DEPTH];
    logic [DEPTH-1:0]  nb_s2_rdy;
    logic [TAG_W-1:0]  nb_s2_tag [DEPTH];
    logic [DATA_W-1:0] nb_s2_val [DEPTH];

    logic              alu_valid_r;
    logic [OP_W-1:0]   alu_opcode_r;
    logic [DATA_W-1:0] alu_src1_r;
    logic [DATA_W-1:0] alu_src2_r;
    logic [TAG_W-1:0]  alu_dst_tag_r;

    logic              in_ready_s;
    logic              sel_found_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              issue_s;
    logic              alloc_s;
    logic [CNT_W-1:0]  wr_idx_s;
    logic [DEPTH-1:0]  load_s;
    logic [DEPTH-1:0]  shift_s;

    assign in_ready_s = (count_r < CNT_W'(DEPTH));

    // Lowest-index ready entry from registered state; scanning downward lets the lowest win.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_r[i] && s1_rdy[i] && s2_rdy[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Flush dominates: it suppresses both issue and allocation.
    always_comb begin
        issue_s  = sel_found_s & ~bus.flush;
        alloc_s  = bus.in_valid & in_ready_s & ~bus.flush;
        wr_idx_s = issue_s ? (count_r - CNT_W'(1)) : count_r;
        for (int i = 0; i < DEPTH; i++) begin
            load_s[i]  = alloc_s & (wr_idx_s == CNT_W'(i));
            shift_s[i] = issue_s & (i >= int'(sel_idx_s));
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i < DEPTH - 1) begin : g_nb
            assign nb_valid[i]  = valid_r[i+1];
            assign nb_opcode[i] = opcode_r[i+1];
            assign nb_dst[i]    = dst_r[i+1];
            assign nb_s1_rdy[i] = s1_rdy[i+1];
            assign nb_s1_tag[i] = s1_tag[i+1];
            assign nb_s1_val[i] = s1_val[i+1];
            assign nb_s2_rdy[i] = s2_rdy[i+1];
            assign nb_s2_tag[i] = s2_tag[i+1];
            assign nb_s2_val[i] = s2_val[i+1];
        end else begin : g_last
            assign nb_valid[i]  = 1'b0;
            assign nb_opcode[i] = '0;
            assign nb_dst[i]    = '0;
            assign nb_s1_rdy[i] = 1'b0;
            assign nb_s1_tag[i] = '0;
            assign nb_s1_val[i] = '0;
            assign nb_s2_rdy[i] = 1'b0;
            assign nb_s2_tag[i] = '0;
            assign nb_s2_val[i] = '0;
        end

        alu_rs_operand #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src1 (
            .clk         (clk),
            .rst         (rst),
            .clr         (bus.flush),
            .entry_valid (valid_r[i]),
            .nb_valid    (nb_valid[i]),
            .cdb_valid   (bus.cdb_valid),
            .cdb_tag     (bus.cdb_tag),
            .cdb_data    (bus.cdb_data),
            .load_new    (load_s[i]),
            .new_rdy     (bus.in_src1_rdy),
            .new_tag     (bus.in_src1_tag),
            .new_val     (bus.in_src1),
            .shift       (shift_s[i]),
            .nb_rdy      (nb_s1_rdy[i]),
            .nb_tag      (nb_s1_tag[i]),
            .nb_val      (nb_s1_val[i]),
            .rdy         (s1_rdy[i]),
            .tag         (s1_tag[i]),
            .val         (s1_val[i])
        );

        alu_rs_operand #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src2 (
            .clk         (clk),
            .rst         (rst),
            .clr         (bus.flush),
            .entry_valid (valid_r[i]),
            .nb_valid    (nb_valid[i]),
            .cdb_valid   (bus.cdb_valid),
            .cdb_tag     (bus.cdb_tag),
            .cdb_data    (bus.cdb_data),
            .load_new    (load_s[i]),
            .new_rdy     (bus.in_src2_rdy),
            .new_tag     (bus.in_src2_tag),
            .new_val     (bus.in_src2),
            .shift       (shift_s[i]),
            .nb_rdy      (nb_s2_rdy[i]),
            .nb_tag      (nb_s2_tag[i]),
            .nb_val      (nb_s2_val[i]),
            .rdy         (s2_rdy[i]),
            .tag         (s2_tag[i]),
            .val         (s2_val[i])
        );
    end

    // Entry valid/opcode/destination with compaction; a new op takes priority at its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opcode_r[i] <= '0;
                dst_r[i]    <= '0;
            end
        end else if (bus.flush) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_s[i]) begin
                    valid_r[i]  <= 1'b1;
                    opcode_r[i] <= bus.in_opcode;
                    dst_r[i]    <= bus.in_dst_tag;
                end else if (shift_s[i]) begin
                    valid_r[i]  <= nb_valid[i];
                    opcode_r[i] <= nb_opcode[i];
                    dst_r[i]    <= nb_dst[i];
                end
            end
        end
    end

    // Occupancy and the registered issue port; payload holds when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r       <= '0;
            alu_valid_r   <= 1'b0;
            alu_opcode_r  <= '0;
            alu_src1_r    <= '0;
            alu_src2_r    <= '0;
            alu_dst_tag_r <= '0;
        end else if (bus.flush) begin
            count_r     <= '0;
            alu_valid_r <= 1'b0;
        end else begin
            count_r     <= count_r + CNT_W'(alloc_s) - CNT_W'(issue_s);
            alu_valid_r <= issue_s;
            if (issue_s) begin
                alu_opcode_r  <= opcode_r[sel_idx_s];
                alu_src1_r    <= s1_val[sel_idx_s];
                alu_src2_r    <= s2_val[sel_idx_s];
                alu_dst_tag_r <= dst_r[sel_idx_s];
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.count       = count_r;
    assign bus.alu_valid   = alu_valid_r;
    assign bus.alu_opcode  = alu_opcode_r;
    assign bus.alu_src1    = alu_src1_r;
    assign bus.alu_src2    = alu_src2_r;
    assign bus.alu_dst_tag = alu_dst_tag_r;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic
// against a queue-based model of the station.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int DEPTH = RS_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_rs_if bus ();
    alu_rs dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  dst;
        logic        r1;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [3:0]  t2;
        logic [31:0] v2;
    } ent_t;

    ent_t        q[$];
    logic        exp_valid;
    logic [3:0]  exp_op;
    logic [3:0]  exp_dst;
    logic [31:0] exp_s1;
    logic [31:0] exp_s2;

    task automatic idle();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_opcode = 4'd0; bus.in_dst_tag = 4'd0;
        bus.in_src1_rdy = 1'b0; bus.in_src1 = 32'd0; bus.in_src1_tag = 4'd0;
        bus.in_src2_rdy = 1'b0; bus.in_src2 = 32'd0; bus.in_src2_tag = 4'd0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = 4'd0; bus.cdb_data = 32'd0;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [3:0] dst,
                            input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_dst_tag = dst;
        bus.in_src1_rdy = r1; bus.in_src1_tag = t1; bus.in_src1 = v1;
        bus.in_src2_rdy = r2; bus.in_src2_tag = t2; bus.in_src2 = v2;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid = v; bus.cdb_tag = tag; bus.cdb_data = data;
    endtask

    task automatic model_reset();
        q.delete();
        exp_valid = 1'b0; exp_op = 4'd0; exp_dst = 4'd0; exp_s1 = 32'd0; exp_s2 = 32'd0;
    endtask

    // Queue model of one clock edge: oldest ready op leaves, broadcasts wake waiters, new op joins the tail.
    task automatic model_edge();
        int   sel;
        ent_t e;
        bit   take;
        sel = -1;
        if (bus.flush) begin
            q.delete();
            exp_valid = 1'b0;
            return;
        end
        take = bus.in_valid && (q.size() < DEPTH);
        for (int i = 0; i < q.size(); i++)
            if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
        if (sel >= 0) begin
            exp_valid = 1'b1; exp_op = q[sel].op; exp_dst = q[sel].dst;
            exp_s1 = q[sel].v1; exp_s2 = q[sel].v2;
            q.delete(sel);
        end else begin
            exp_valid = 1'b0;
        end
        if (bus.cdb_valid) begin
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].r1 && q[i].t1 == bus.cdb_tag) begin q[i].r1 = 1'b1; q[i].v1 = bus.cdb_data; end
                if (!q[i].r2 && q[i].t2 == bus.cdb_tag) begin q[i].r2 = 1'b1; q[i].v2 = bus.cdb_data; end
            end
        end
        if (take) begin
            e.op = bus.in_opcode; e.dst = bus.in_dst_tag;
            e.r1 = bus.in_src1_rdy; e.t1 = bus.in_src1_tag; e.v1 = bus.in_src1;
            e.r2 = bus.in_src2_rdy; e.t2 = bus.in_src2_tag; e.v2 = bus.in_src2;
            if (!e.r1 && bus.cdb_valid && e.t1 == bus.cdb_tag) begin e.r1 = 1'b1; e.v1 = bus.cdb_data; end
            if (!e.r2 && bus.cdb_valid && e.t2 == bus.cdb_tag) begin e.r2 = 1'b1; e.v2 = bus.cdb_data; end
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else passed++;
        checks++; if (bus.alu_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.alu_valid); else passed++;
        checks++; if (bus.alu_src1 !== 32'd0 || bus.alu_src2 !== 32'd0 || bus.alu_opcode !== 4'd0 || bus.alu_dst_tag !== 4'd0)
            $display("FAIL reset_payload: got %h/%h/%h/%h want zeros", bus.alu_opcode, bus.alu_src1, bus.alu_src2, bus.alu_dst_tag);
        else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ready_op();
        dispatch(ALU_ADD, 4'd5, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4);
        cycle();
        idle();
        checks++; if (bus.alu_valid !== 1'b0 || bus.count !== 3'd1)
            $display("FAIL ready_latency: got valid=%b count=%0d want valid=0 count=1", bus.alu_valid, bus.count);
        else passed++;
        cycle();
        checks++; if (bus.alu_valid !== 1'b1 || bus.alu_opcode !== ALU_ADD || bus.alu_dst_tag !== 4'd5)
            $display("FAIL ready_issue: got valid=%b op=%0d dst=%0d want 1/0/5", bus.alu_valid, bus.alu_opcode, bus.alu_dst_tag);
        else passed++;
        checks++; if (bus.alu_src1 !== 32'd3 || bus.alu_src2 !== 32'd4 || bus.count !== 3'd0)
            $display("FAIL ready_data: got %0d/%0d count=%0d want 3/4 count=0", bus.alu_src1, bus.alu_src2, bus.count);
        else passed++;
    endtask

    task automatic test_wakeup();
        dispatch(ALU_SUB, 4'd6, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd7);
        cycle();
        idle();
        cycle();
        checks++; if (bus.alu_valid !== 1'b0 || bus.count !== 3'd1)
            $display("FAIL wake_wait: got valid=%b count=%0d want 0/1", bus.alu_valid, bus.count);
        else passed++;
        set_cdb(1'b1, 4'd2, 32'd9);
        cycle();
        idle();
        checks++; if (bus.alu_valid !== 1'b0) $display("FAIL wake_same_cycle: got %b want 0", bus.alu_valid); else passed++;
        cycle();
        checks++; if (bus.alu_valid !== 1'b1 || bus.alu_src1 !== 32'd9 || bus.alu_src2 !== 32'd7 || bus.alu_dst_tag !== 4'd6)
            $display("FAIL wake_issue: got v=%b %0d/%0d dst=%0d want 1 9/7 dst=6", bus.alu_valid, bus.alu_src1, bus.alu_src2, bus.alu_dst_tag);
        else passed++;
    endtask

    task automatic test_oldest_first();
        logic [3:0] want;
        dispatch(ALU_OR, 4'd1, 1'b0, 4'd8, 32'd0, 1'b1, 4'd0, 32'h100);
        cycle();
        for (int d = 2; d <= 4; d++) begin
            dispatch(ALU_AND, 4'(d), 1'b1, 4'd0, 32'(d * 16), 1'b0, 4'd9, 32'd0);
            cycle();
        end
        idle();
        checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0)
            $display("FAIL oldest_full: got count=%0d ready=%b want 4/0", bus.count, bus.in_ready);
        else passed++;
        set_cdb(1'b1, 4'd9, 32'h11);
        cycle();
        idle();
        for (int d = 2; d <= 4; d++) begin
            cycle();
            want = 4'(d);
            checks++; if (bus.alu_valid !== 1'b1 || bus.alu_dst_tag !== want || bus.alu_src1 !== 32'(d * 16) || bus.alu_src2 !== 32'h11)
                $display("FAIL oldest_order: got v=%b dst=%0d src=%h/%h want dst=%0d", bus.alu_valid, bus.alu_dst_tag, bus.alu_src1, bus.alu_src2, want);
            else passed++;
        end
        set_cdb(1'b1, 4'd8, 32'h22);
        cycle();
        idle();
        cycle();
        checks++; if (bus.alu_valid !== 1'b1 || bus.alu_dst_tag !== 4'd1 || bus.alu_src1 !== 32'h22 || bus.count !== 3'd0)
            $display("FAIL oldest_last: got v=%b dst=%0d src1=%h count=%0d want 1/1/22/0", bus.alu_valid, bus.alu_dst_tag, bus.alu_src1, bus.count);
        else passed++;
    endtask

    task automatic test_bypass();
        dispatch(ALU_XOR, 4'd9, 1'b1, 4'd0, 32'd1, 1'b0, 4'd6, 32'd0);
        set_cdb(1'b1, 4'd6, 32'hA5);
        cycle();
        idle();
        checks++; if (bus.alu_valid !== 1'b0 || bus.count !== 3'd1)
            $display("FAIL bypass_store: got v=%b count=%0d want 0/1", bus.alu_valid, bus.count);
        else passed++;
        cycle();
        checks++; if (bus.alu_valid !== 1'b1 || bus.alu_src2 !== 32'hA5 || bus.alu_dst_tag !== 4'd9)
            $display("FAIL bypass_issue: got v=%b src2=%h dst=%0d want 1/a5/9", bus.alu_valid, bus.alu_src2, bus.alu_dst_tag);
        else passed++;
    endtask

    task automatic test_full();
        dispatch(ALU_AND, 4'd1, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'h5);  cycle();
        dispatch(ALU_OR,  4'd2, 1'b0, 4'd11, 32'd0, 1'b1, 4'd0, 32'h6);  cycle();
        dispatch(ALU_XOR, 4'd3, 1'b1, 4'd0, 32'h30, 1'b0, 4'd12, 32'd0); cycle();
        dispatch(ALU_SLL, 4'd4, 1'b1, 4'd0, 32'h40, 1'b0, 4'd12, 32'd0); cycle();
        dispatch(ALU_SUB, 4'd5, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
        set_cdb(1'b1, 4'd12, 32'h7);
        cycle();
        set_cdb(1'b0, 4'd0, 32'd0);
        checks++; if (bus.count !== 3'd4 || bus.alu_valid !== 1'b0)
            $display("FAIL full_ignore: got count=%0d v=%b want 4/0", bus.count, bus.alu_valid);
        else passed++;
        cycle();
        checks++; if (bus.alu_valid !== 1'b1 || bus.alu_dst_tag !== 4'd3 || bus.count !== 3'd3 || bus.alu_src2 !== 32'h7)
            $display("FAIL full_issue: got v=%b dst=%0d count=%0d src2=%h want 1/3/3/7", bus.alu_valid, bus.alu_dst_tag, bus.count, bus.alu_src2);
        else passed++;
        cycle();
        idle();
        checks++; if (bus.alu_valid !== 1'b1 || bus.alu_dst_tag !== 4'd4 || bus.count !== 3'd3 || bus.alu_src1 !== 32'h40)
            $display("FAIL full_alloc_issue: got v=%b dst=%0d count=%0d src1=%h want 1/4/3/40", bus.alu_valid, bus.alu_dst_tag, bus.count, bus.alu_src1);
        else passed++;
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        dispatch(ALU_ADD, 4'd7, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        cycle();
        idle();
        checks++; if (bus.count !== 3'd0 || bus.alu_valid !== 1'b0)
            $display("FAIL flush_clear: got count=%0d v=%b want 0/0", bus.count, bus.alu_valid);
        else passed++;
        cycle();
        checks++; if (bus.count !== 3'd0 || bus.alu_valid !== 1'b0)
            $display("FAIL flush_drop: got count=%0d v=%b want 0/0", bus.count, bus.alu_valid);
        else passed++;
    endtask

    task automatic test_reset_async();
        for (int k = 0; k < 3; k++) begin
            dispatch(ALU_ADD, 4'(k), 1'b0, 4'd14, 32'd0, 1'b1, 4'd0, 32'd1);
            cycle();
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.alu_valid !== 1'b0 || bus.alu_src1 !== 32'd0 || bus.alu_src2 !== 32'd0 || bus.alu_dst_tag !== 4'd0 || bus.alu_opcode !== 4'd0)
            $display("FAIL async_reset: got count=%0d v=%b op=%0d src=%h/%h dst=%0d want zeros", bus.count, bus.alu_valid, bus.alu_opcode, bus.alu_src1, bus.alu_src2, bus.alu_dst_tag);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (bus.count !== 3'd0 || bus.alu_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL async_after: got count=%0d v=%b ready=%b want 0/0/1", bus.count, bus.alu_valid, bus.in_ready);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 2) != 0)
                dispatch(4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)), $urandom,
                         1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) != 0) set_cdb(1'b1, 4'($urandom_range(0, 7)), $urandom);
            bus.flush = ($urandom_range(0, 39) == 0);
            cycle();
            checks++; if (bus.alu_valid !== exp_valid) $display("FAIL rnd_valid n=%0d: got %b want %b", n, bus.alu_valid, exp_valid); else passed++;
            checks++; if (bus.alu_opcode !== exp_op || bus.alu_dst_tag !== exp_dst)
                $display("FAIL rnd_ctl n=%0d: got op=%0d dst=%0d want op=%0d dst=%0d", n, bus.alu_opcode, bus.alu_dst_tag, exp_op, exp_dst);
            else passed++;
            checks++; if (bus.alu_src1 !== exp_s1 || bus.alu_src2 !== exp_s2)
                $display("FAIL rnd_data n=%0d: got %h/%h want %h/%h", n, bus.alu_src1, bus.alu_src2, exp_s1, exp_s2);
            else passed++;
            checks++; if (int'(bus.count) != q.size() || bus.in_ready !== (q.size() < DEPTH))
                $display("FAIL rnd_count n=%0d: got count=%0d ready=%b want count=%0d", n, bus.count, bus.in_ready, q.size());
            else passed++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ready_op();
        test_wakeup();
        test_oldest_first();
        test_bypass();
        test_full();
        test_flush();
        test_reset_async();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
